// File: rtl/adder_share_arb.sv
// Round-robin share of one external 2-bit full adder among NREQ requesters.
// Each accepted WIDTH-bit add is rippled through the adder two bits per
// cycle, LSB slice first, and returned as one tagged response.
module adder_share_arb #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int S    = WIDTH / 2,
  localparam int KW   = (S > 1) ? $clog2(S) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic [1:0]            add_a,
  output logic [1:0]            add_b,
  output logic                  add_cin,
  input  logic [1:0]            add_sum,
  input  logic                  add_cout
);

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  state_t           state_q;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   id_q;
  logic [KW-1:0]    k_q;
  logic             carry_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic             cin_q;

  logic             grant_vld;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   cand;
  logic [WIDTH-1:0] opa_sh;
  logic [WIDTH-1:0] opb_sh;

  // Round-robin search: first valid requester at or above ptr, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int j = 0; j < NREQ; j++) begin
      cand = IDW'((int'(ptr_q) + j) % NREQ);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Accept only in IDLE; reset forces ready low immediately.
  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == IDLE && grant_vld) req_ready[grant_idx] = 1'b1;
  end

  // Drive the current slice into the shared adder; quiet outside RUN.
  always_comb begin
    opa_sh  = opa_q >> {k_q, 1'b0};
    opb_sh  = opb_q >> {k_q, 1'b0};
    add_a   = 2'b00;
    add_b   = 2'b00;
    add_cin = 1'b0;
    if (state_q == RUN) begin
      add_a   = opa_sh[1:0];
      add_b   = opb_sh[1:0];
      add_cin = (k_q == '0) ? cin_q : carry_q;
    end
  end

  // Operand capture on the accept edge; no reset needed, only read in RUN.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && grant_vld) begin
      opa_q <= req_a[grant_idx*WIDTH +: WIDTH];
      opb_q <= req_b[grant_idx*WIDTH +: WIDTH];
      cin_q <= req_cin[grant_idx];
    end
  end

  // Sequencer: accept, ripple S slices, then hold the result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_vld) begin
            id_q    <= grant_idx;
            k_q     <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[{k_q, 1'b0} +: 2] <= add_sum;
          carry_q                 <= add_cout;
          k_q                     <= k_q + 1'b1;
          if (k_q == KW'(S - 1)) begin
            cout_q  <= add_cout;
            k_q     <= '0;
            state_q <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            ptr_q   <= (int'(id_q) == NREQ - 1) ? '0 : id_q + 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign rsp_id    = id_q;

endmodule
